// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: EX_MEM field offsets, MemToReg encodings, FSM states.
package mem_pkg;

  localparam int EX_MEM_W = 139;
  localparam int SD_LO    = 0;
  localparam int SD_HI    = 31;
  localparam int ALU_LO   = 32;
  localparam int ALU_HI   = 63;
  localparam int WR_LO    = 64;
  localparam int WR_HI    = 68;
  localparam int MR_BIT   = 69;
  localparam int MW_BIT   = 70;
  localparam int RW_BIT   = 71;
  localparam int MTR_LO   = 72;
  localparam int MTR_HI   = 73;
  localparam int PC4_LO   = 74;
  localparam int PC4_HI   = 105;
  localparam int LUD_LO   = 106;
  localparam int LUD_HI   = 137;
  localparam int LUOP_BIT = 138;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_wb_select.sv
// Writeback value mux: LUOp selects LUData, otherwise MemToReg picks ALU / load data / PC+4 / zero.
module mem_wb_select
  import mem_pkg::*;
(
  input  logic        lu_op_i,
  input  logic [1:0]  mem_to_reg_i,
  input  logic [31:0] lu_data_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] mem_i,
  output logic [31:0] wb_o
);

  // Writeback source selection
  always_comb begin
    wb_o = 32'h0000_0000;
    if (lu_op_i) begin
      wb_o = lu_data_i;
    end else begin
      case (mem_to_reg_i)
        MTR_ALU: wb_o = alu_i;
        MTR_MEM: wb_o = mem_i;
        MTR_PC4: wb_o = pc4_i;
        default: wb_o = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access with timeout, MEM_WB register and EX forwarding.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are dropped and flagged on mem_misalign.
module mem_stage
  import mem_pkg::*;
#(
  parameter int          ACK_TIMEOUT   = 16,
  parameter logic [31:0] TIMEOUT_RDATA = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [EX_MEM_W-1:0] EX_MEM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ack,
  output logic                mem_stall,
  output logic                mem_timeout,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                mem_misalign,
`endif
  output logic [4:0]          EX_MEM_Rd,
  output logic [31:0]         EX_MEM_RdData,
  output logic                EX_MEM_RegWrite,
  output logic [4:0]          MEM_WB_Rd,
  output logic [31:0]         MEM_WB_RdData,
  output logic                MEM_WB_RegWrite
);

  logic [31:0] sd_s, alu_s, pc4_s, lud_s;
  logic [4:0]  wr_s;
  logic [1:0]  mtr_s, mtr_fwd_s;
  logic        mr_s, mw_s, rw_s, luop_s;
  logic        access_s, misalign_s, start_s, expire_s;
  logic [31:0] wb_val_s, fwd_val_s;

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, to_q, to_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_rw_q, wb_rw_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  assign sd_s   = EX_MEM[SD_HI:SD_LO];
  assign alu_s  = EX_MEM[ALU_HI:ALU_LO];
  assign wr_s   = EX_MEM[WR_HI:WR_LO];
  assign mr_s   = EX_MEM[MR_BIT];
  assign mw_s   = EX_MEM[MW_BIT];
  assign rw_s   = EX_MEM[RW_BIT];
  assign mtr_s  = EX_MEM[MTR_HI:MTR_LO];
  assign pc4_s  = EX_MEM[PC4_HI:PC4_LO];
  assign lud_s  = EX_MEM[LUD_HI:LUD_LO];
  assign luop_s = EX_MEM[LUOP_BIT];

  assign access_s = mr_s | mw_s;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = access_s & (alu_s[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif
  assign start_s  = access_s & ~misalign_s;
  assign expire_s = (cnt_q == 8'(ACK_TIMEOUT - 1));

  // Forwarding never sees load data, so MemToReg collapses to PC+4 or ALU
  assign mtr_fwd_s = (mtr_s == MTR_PC4) ? MTR_PC4 : MTR_ALU;

  mem_wb_select u_fwd_sel (
    .lu_op_i      (luop_s),
    .mem_to_reg_i (mtr_fwd_s),
    .lu_data_i    (lud_s),
    .alu_i        (alu_s),
    .pc4_i        (pc4_s),
    .mem_i        (32'h0000_0000),
    .wb_o         (fwd_val_s)
  );

  mem_wb_select u_wb_sel (
    .lu_op_i      (luop_s),
    .mem_to_reg_i (mtr_s),
    .lu_data_i    (lud_s),
    .alu_i        (alu_s),
    .pc4_i        (pc4_s),
    .mem_i        (rdata_q),
    .wb_o         (wb_val_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = WAIT;
        else         state_d = IDLE;
      end
      WAIT: begin
        if (dmem_ack || expire_s) state_d = DONE;
        else                      state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values; an ack in the expiry cycle takes priority
  always_comb begin
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    to_d      = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_rw_d   = wb_rw_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_s) begin
          req_d   = 1'b1;
          we_d    = mw_s;
          addr_d  = {alu_s[31:2], 2'b00};
          wdata_d = sd_s;
          cnt_d   = 8'd0;
          wb_rw_d = 1'b0;
        end else if (access_s) begin
          wb_rw_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          mis_d   = 1'b1;
`endif
        end else begin
          wb_rd_d   = wr_s;
          wb_data_d = wb_val_s;
          wb_rw_d   = rw_s;
        end
      end
      WAIT: begin
        cnt_d   = cnt_q + 8'd1;
        wb_rw_d = 1'b0;
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = dmem_rdata;
        end else if (expire_s) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = TIMEOUT_RDATA;
          to_d    = 1'b1;
        end else begin
          req_d   = 1'b1;
        end
      end
      DONE: begin
        wb_rd_d   = wr_s;
        wb_data_d = wb_val_s;
        wb_rw_d   = rw_s;
        cnt_d     = 8'd0;
      end
      default: begin
        req_d = 1'b0;
        we_d  = 1'b0;
        cnt_d = 8'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      to_q      <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'h0000_0000;
      wb_rw_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      to_q      <= to_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_rw_q   <= wb_rw_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Stall is held low during reset so upstream is never frozen by an aborted access
  assign mem_stall = reset_b & (((state_q == IDLE) & start_s) | (state_q == WAIT));

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign mem_timeout     = to_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign mem_misalign    = mis_q;
`endif
  assign EX_MEM_Rd       = wr_s;
  assign EX_MEM_RdData   = fwd_val_s;
  assign EX_MEM_RegWrite = rw_s & ~mr_s;
  assign MEM_WB_Rd       = wb_rd_q;
  assign MEM_WB_RdData   = wb_data_q;
  assign MEM_WB_RegWrite = wb_rw_q;

endmodule
